// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller: states, opcodes/functs,
// datapath mux selects and the one-hot instruction flag bundle.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MDR = 2'd1;
   localparam logic [1:0] WD_PC  = 2'd2;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [1:0] ALU_LUI = 2'd3;

   localparam logic [1:0] EXT_ZERO = 2'd0;
   localparam logic [1:0] EXT_SIGN = 2'd1;
   localparam logic [1:0] EXT_HIGH = 2'd2;

   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic nop;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic jal;
   } instr_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and memory handshake in, mux selects and enables out.
// illegal exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        iord;
   logic        reg_write;
   logic [1:0]  reg_dst;
   logic [1:0]  wd_sel;
   logic        alu_src;
   logic [1:0]  alu_op;
   logic [1:0]  ext_op;
   logic        retire;
   logic [31:0] instr_count;
   logic [2:0]  state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
             reg_dst, wd_sel, alu_src, alu_op, ext_op, retire, instr_count, state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , output illegal
`endif
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
             reg_dst, wd_sel, alu_src, alu_op, ext_op, retire, instr_count, state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , input illegal
`endif
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct to one-hot instruction flags; illegal flags anything unrecognised.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output instr_t     ins,
   output logic       illegal
);

   always_comb begin
      ins = '0;
      unique case (opcode)
         OP_RTYPE: begin
            ins.addu = (funct == FN_ADDU);
            ins.subu = (funct == FN_SUBU);
            ins.jr   = (funct == FN_JR);
            ins.nop  = (funct == FN_NOP);
         end
         OP_ORI:  ins.ori = 1'b1;
         OP_LW:   ins.lw  = 1'b1;
         OP_SW:   ins.sw  = 1'b1;
         OP_BEQ:  ins.beq = 1'b1;
         OP_LUI:  ins.lui = 1'b1;
         OP_JAL:  ins.jal = 1'b1;
         default: ins = '0;
      endcase
      illegal = (ins == '0);
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready stall and retire counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unrecognised instructions halt and set sticky illegal.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   mc_ctrl_if.master bus
);

   state_t      st, nxt;
   logic [31:0] cnt_q;
   instr_t      ins;
   logic        ins_illegal;

   logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, alu_src, retire;
   logic [1:0] pc_src, reg_dst, wd_sel, alu_op, ext_op;

   mc_decode u_decode (
      .opcode  (bus.opcode),
      .funct   (bus.funct),
      .ins     (ins),
      .illegal (ins_illegal)
   );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic ill_q;
   assign bus.illegal = ill_q;
`endif

   always_comb begin
      nxt       = st;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      reg_write = 1'b0;
      reg_dst   = RD_RT;
      wd_sel    = WD_ALU;
      alu_src   = 1'b0;
      alu_op    = ALU_ADD;
      ext_op    = EXT_ZERO;
      retire    = 1'b0;
      case (st)
         S_FETCH: begin
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end
         end
         S_DECODE: begin
            if (ins.jal) begin
               reg_write = 1'b1;
               reg_dst   = RD_RA;
               wd_sel    = WD_PC;
               pc_write  = 1'b1;
               pc_src    = PC_JUMP;
               retire    = 1'b1;
               nxt       = S_FETCH;
            end else if (ins.jr) begin
               pc_write = 1'b1;
               pc_src   = PC_REG;
               retire   = 1'b1;
               nxt      = S_FETCH;
            end else if (ins.nop) begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end else if (ins_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               nxt    = S_HALT;
`else
               retire = 1'b1;
               nxt    = S_FETCH;
`endif
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            nxt = S_WB;
            if (ins.subu) begin
               alu_op = ALU_SUB;
            end else if (ins.ori) begin
               alu_op  = ALU_OR;
               alu_src = 1'b1;
            end else if (ins.lui) begin
               alu_op  = ALU_LUI;
               alu_src = 1'b1;
               ext_op  = EXT_HIGH;
            end else if (ins.lw || ins.sw) begin
               alu_src = 1'b1;
               ext_op  = EXT_SIGN;
               nxt     = S_MEM;
            end else if (ins.beq) begin
               alu_op   = ALU_SUB;
               pc_write = bus.zero;
               pc_src   = PC_BRANCH;
               retire   = 1'b1;
               nxt      = S_FETCH;
            end else if (!ins.addu) begin
               nxt = S_FETCH;
            end
         end
         S_MEM: begin
            // Request stays asserted unchanged until the memory acknowledges it.
            iord      = 1'b1;
            mem_read  = ins.lw;
            mem_write = ins.sw;
            if (bus.mem_ready) begin
               retire = ins.sw;
               nxt    = ins.lw ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            reg_dst   = (bus.opcode == OP_RTYPE) ? RD_RD : RD_RT;
            wd_sel    = ins.lw ? WD_MDR : WD_ALU;
            nxt       = S_FETCH;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         S_HALT: nxt = S_HALT;
`endif
         default: nxt = S_FETCH;
      endcase
      // Nothing may reach the datapath or memory while reset is held.
      if (!rst_n) begin
         pc_write  = 1'b0;
         pc_src    = PC_PLUS4;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         iord      = 1'b0;
         reg_write = 1'b0;
         reg_dst   = RD_RT;
         wd_sel    = WD_ALU;
         alu_src   = 1'b0;
         alu_op    = ALU_ADD;
         ext_op    = EXT_ZERO;
         retire    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= S_FETCH;
         cnt_q <= 32'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         ill_q <= 1'b0;
`endif
      end else begin
         st <= nxt;
         if (retire) cnt_q <= cnt_q + 32'd1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         if (st == S_DECODE && ins_illegal) ill_q <= 1'b1;
`endif
      end
   end

   assign bus.pc_write    = pc_write;
   assign bus.pc_src      = pc_src;
   assign bus.ir_write    = ir_write;
   assign bus.mem_read    = mem_read;
   assign bus.mem_write   = mem_write;
   assign bus.iord        = iord;
   assign bus.reg_write   = reg_write;
   assign bus.reg_dst     = reg_dst;
   assign bus.wd_sel      = wd_sel;
   assign bus.alu_src     = alu_src;
   assign bus.alu_op      = alu_op;
   assign bus.ext_op      = ext_op;
   assign bus.retire      = retire;
   assign bus.instr_count = cnt_q;
   assign bus.state       = st;

endmodule
